// File: rtl/alarm_timer_pkg.sv
// Shared constants for the alarm countdown timer: interval encodings,
// power-up delay values and the countdown state encoding.
package alarm_timer_pkg;

  localparam logic [1:0] INT_ARM    = 2'b00;
  localparam logic [1:0] INT_DRIVER = 2'b01;
  localparam logic [1:0] INT_PASS   = 2'b10;
  localparam logic [1:0] INT_ALARM  = 2'b11;

  localparam logic [3:0] DEF_ARM    = 4'd6;
  localparam logic [3:0] DEF_DRIVER = 4'd8;
  localparam logic [3:0] DEF_PASS   = 4'd15;
  localparam logic [3:0] DEF_ALARM  = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [3:0] default_param(input logic [1:0] sel);
    logic [3:0] val;
    case (sel)
      INT_ARM:    val = DEF_ARM;
      INT_DRIVER: val = DEF_DRIVER;
      INT_PASS:   val = DEF_PASS;
      default:    val = DEF_ALARM;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/alarm_timer_if.sv
// Controller <-> timer link: start request with delay selector, the
// parameter programming strobe, and the returned expiry pulse.
interface alarm_timer_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  expired
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output expired
  );
endinterface

// File: rtl/one_hz_divider.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ cycles;
// restart snaps the phase back to zero so a new countdown gets full seconds.
module one_hz_divider #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic one_hz_enable
);

  localparam int W = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] DIV_MAX = W'(CLK_FREQ - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    div_d = div_q + W'(1);
    if (restart || div_q == DIV_MAX) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign one_hz_enable = (div_q == DIV_MAX);

endmodule

// File: rtl/alarm_timer.sv
// Countdown timer with four reprogrammable delays and the shared 1 Hz tick.
// Optional seconds-remaining output enabled by ALARM_TIMER_REMAIN_EN.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic           clock,
  input  logic           reset,
  alarm_timer_if.slave   tmr,
  output logic           one_hz_enable
`ifdef ALARM_TIMER_REMAIN_EN
  ,
  output logic [3:0]     remaining
`endif
);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       start_q, start_d;
  logic [1:0] interval_q, interval_d;
  logic [3:0] param_val [4];
  logic       start_ev;
  logic       load;
  logic       tick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_param
    logic [3:0] p_q;
    logic [3:0] p_d;

    always_comb begin
      p_d = p_q;
      if (tmr.reprogram && tmr.time_param_sel == 2'(gi)) begin
        p_d = tmr.time_value;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        p_q <= default_param(2'(gi));
      end else begin
        p_q <= p_d;
      end
    end

    assign param_val[gi] = p_q;
  end

  // An interval change while start is held counts as a fresh request.
  assign start_ev = tmr.start_timer && (!start_q || (tmr.interval != interval_q));
  assign load     = start_ev && !tmr.reprogram;

  one_hz_divider #(
    .CLK_FREQ (CLK_FREQ)
  ) u_div (
    .clock         (clock),
    .reset         (reset),
    .restart       (load),
    .one_hz_enable (tick)
  );

  assign one_hz_enable = tick;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    start_d    = tmr.start_timer;
    interval_d = tmr.interval;
    if (tmr.reprogram) begin
      state_d = IDLE;
    end else if (start_ev) begin
      state_d = COUNT;
      count_d = param_val[tmr.interval];
    end else begin
      case (state_q)
        COUNT: begin
          if (count_q == 4'd0) begin
            state_d = DONE;
          end else if (tick) begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      start_q    <= 1'b0;
      interval_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      start_q    <= start_d;
      interval_q <= interval_d;
    end
  end

  assign tmr.expired = (state_q == DONE);

`ifdef ALARM_TIMER_REMAIN_EN
  assign remaining = (state_q == COUNT) ? count_q : 4'd0;
`endif

endmodule

// File: tb/tb_alarm_timer.sv
// Directed bench for alarm_timer at CLK_FREQ=4: a per-cycle vector table
// followed by hand-written countdown sequences.
module tb_alarm_timer;
  import alarm_timer_pkg::*;

  logic clock;
  logic reset;
  logic one_hz_enable;
`ifdef ALARM_TIMER_REMAIN_EN
  logic [3:0] remaining;
`endif

  alarm_timer_if tmr ();

  alarm_timer #(
    .CLK_FREQ (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tmr           (tmr),
    .one_hz_enable (one_hz_enable)
`ifdef ALARM_TIMER_REMAIN_EN
    ,
    .remaining     (remaining)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       st;
    logic [1:0] itv;
    logic       rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic       ex;
    logic       tk;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic rst, input logic st, input logic [1:0] itv,
                     input logic rp, input logic [1:0] sel, input logic [3:0] val,
                     input logic ex, input logic tk);
    vec_t v;
    v.rst = rst; v.st = st; v.itv = itv; v.rp = rp;
    v.sel = sel; v.val = val; v.ex = ex; v.tk = tk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs up to n cycles, reporting the first cycle with expired and the pulse count.
  task automatic monitor(input int n, output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (tmr.expired) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic seq_start(input logic [1:0] itv);
    tmr.start_timer = 1'b0;
    step();
    tmr.start_timer = 1'b1;
    tmr.interval    = itv;
    step();
  endtask

  initial begin
    int first;
    int pulses;

    reset = 1'b1;
    tmr.start_timer = 1'b0;
    tmr.interval = 2'b00;
    tmr.reprogram = 1'b0;
    tmr.time_param_sel = 2'b00;
    tmr.time_value = 4'd0;

    // rst st itv rp sel val | expired tick
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) add(0, 0, 0, 0, 0, 0, 0, (k % 4 == 3));
    add(0, 0, 0, 1, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 7; j++) add(0, 1, 0, 0, 0, 0, 0, (j % 4 == 3));
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      reset              = vecs[i].rst;
      tmr.start_timer    = vecs[i].st;
      tmr.interval       = vecs[i].itv;
      tmr.reprogram      = vecs[i].rp;
      tmr.time_param_sel = vecs[i].sel;
      tmr.time_value     = vecs[i].val;
      step();
      $display("vec %0d: expired=%0b tick=%0b", i, tmr.expired, one_hz_enable);
      chk($sformatf("vec%0d_expired", i), int'(tmr.expired), int'(vecs[i].ex));
      chk($sformatf("vec%0d_tick", i), int'(one_hz_enable), int'(vecs[i].tk));
    end
    tmr.reprogram = 1'b0;

    // Driver delay 8 s, start held afterwards.
    tmr.start_timer = 1'b1;
    tmr.interval    = INT_DRIVER;
    step();
`ifdef ALARM_TIMER_REMAIN_EN
    chk("driver_remaining", int'(remaining), 8);
`endif
    monitor(60, first, pulses);
    $display("driver: first=%0d pulses=%0d", first, pulses);
    chk("driver_first", first, 32);
    chk("driver_pulses", pulses, 1);

    // Passenger count handed off to alarm while start stays high.
    seq_start(INT_PASS);
    monitor(9, first, pulses);
    chk("pass_no_pulse", pulses, 0);
    tmr.interval = INT_ALARM;
    step();
    monitor(50, first, pulses);
    $display("handoff: first=%0d pulses=%0d", first, pulses);
    chk("handoff_first", first, 40);
    chk("handoff_pulses", pulses, 1);

    // Reprogram aborts a countdown and swallows a simultaneous start event.
    seq_start(INT_DRIVER);
    monitor(10, first, pulses);
    tmr.reprogram      = 1'b1;
    tmr.time_param_sel = INT_ALARM;
    tmr.time_value     = 4'd5;
    tmr.interval       = INT_PASS;
    step();
    tmr.reprogram = 1'b0;
    chk("abort_state", int'(dut.state_q), int'(IDLE));
    monitor(80, first, pulses);
    $display("abort: pulses=%0d", pulses);
    chk("abort_pulses", pulses, 0);
    seq_start(INT_ALARM);
    monitor(30, first, pulses);
    $display("alarm5: first=%0d pulses=%0d", first, pulses);
    chk("alarm5_first", first, 20);

    // Reset mid-countdown restores outputs and default delays.
    seq_start(INT_DRIVER);
    monitor(5, first, pulses);
    reset = 1'b1;
    step();
    chk("rst_expired", int'(tmr.expired), 0);
    chk("rst_tick", int'(one_hz_enable), 0);
`ifdef ALARM_TIMER_REMAIN_EN
    chk("rst_remaining", int'(remaining), 0);
`endif
    reset = 1'b0;
    tmr.start_timer = 1'b0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (one_hz_enable && first == 0) first = i;
    end
    $display("post-reset tick: first=%0d", first);
    chk("rst_first_tick", first, 3);
    seq_start(INT_ARM);
    monitor(30, first, pulses);
    $display("arm default: first=%0d", first);
    chk("rst_arm_default", first, 24);
    seq_start(INT_ALARM);
    monitor(50, first, pulses);
    $display("alarm default: first=%0d", first);
    chk("rst_alarm_default", first, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
